neopixel_frame_fetch: RTL and testbench
=======================================

Name: neopixel_frame_fetch

Overview:
- Upstream stage of the NeoPixel bit serializer.
- Holds a small frame of RGB pixels, written by the host one pixel at a time.
- On START, streams the frame in pixel order as 24-bit words in serializer wire order (G byte in bits [7:0], sent first; R in [15:8]; B in [23:16]) over a valid/ready handshake.
- Pulses FRAME_DONE after the last word is accepted; the serializer owns the latch/reset gap.

Parameters:
- PIXELS, 8: frame buffer depth in pixels.
- ADDR_W, 3: pixel address width; must equal clog2(PIXELS).

Ports:
- CLK_10MHZ  in  1  system clock.
- RESET_N  in  1  reset, asynchronous assert, active-low.
- WR_EN  in  1  host write strobe.
- WR_ADDR  in  ADDR_W  host pixel address.
- WR_DATA  in  24  host pixel, {R[23:16], G[15:8], B[7:0]}.
- START  in  1  one-cycle frame request.
- PIXEL_COUNT  in  ADDR_W+1  pixels to send; sampled on an accepted START.
- BRIGHTNESS  in  8  global scale; used only with the optional feature.
- PIX_DATA  out  24  pixel word for the serializer, {B, R, G}.
- PIX_VALID  out  1  PIX_DATA is valid.
- PIX_READY  in  1  serializer accepts the word.
- BUSY  out  1  frame in progress.
- FRAME_DONE  out  1  one-cycle pulse after the final handshake.

Behaviour:
- Reset values: PIX_DATA=0, PIX_VALID=0, BUSY=0, FRAME_DONE=0, state=IDLE, index=0.
- Reset does not clear buffer contents; they are undefined until written.
- Write port:
  - WR_EN=1 with WR_ADDR<PIXELS stores WR_DATA on the clock edge.
  - WR_ADDR>=PIXELS is ignored.
  - Writes are accepted in every state.
- Read port: synchronous, one-cycle latency, read-first. A same-cycle write to the address being read returns the old data.
- Byte reorder at read: PIX_DATA = {B, R, G}.
- State machine:
  - IDLE: BUSY=0. START=1 with PIXEL_COUNT!=0: latch count = min(PIXEL_COUNT, PIXELS), index=0, go to FETCH. START with PIXEL_COUNT=0 is ignored; no FRAME_DONE.
  - FETCH: BUSY=1; issue a read of index; next state PRESENT.
  - PRESENT: PIX_VALID=1. PIX_DATA holds stable while PIX_READY=0. On VALID&READY: PIX_VALID drops next cycle. If index==count-1, go to DONE; else index+1 and go to FETCH.
  - DONE: FRAME_DONE=1 for exactly one cycle, BUSY=1; next state IDLE.
- Latency:
  - START at cycle t gives PIX_VALID at t+2.
  - A handshake at cycle h gives the next PIX_VALID at h+2 (one bubble cycle, negligible against 288-cycle pixels).
  - The final handshake at h gives FRAME_DONE at h+1.
- START while BUSY=1 is ignored, including in the DONE cycle.
- RESET_N low mid-frame: immediate return to IDLE, PIX_VALID=0, no FRAME_DONE.

Optional Feature:
- Macro: NEOPIXEL_FETCH_BRIGHTNESS_EN.
- Defined:
  - Adds a SCALE state between FETCH and PRESENT.
  - Each channel becomes (c*(BRIGHTNESS+1))>>8 using 16-bit products. BRIGHTNESS=255 is identity; 0 forces zero.
  - BRIGHTNESS is sampled in SCALE.
  - All latencies grow by 1 (START to VALID = t+3).
- Undefined: BRIGHTNESS is ignored and the latencies above apply.

Decomposition:
- Package neopixel_pkg holds:
  - pixel width 24;
  - byte lane positions for host order (R/G/B) and wire order (G/R/B);
  - fetch state encoding (IDLE, FETCH, SCALE, PRESENT, DONE).
- Sub-module neopixel_pixel_ram: PIXELS x 24 single write port, synchronous read-first read port.

Test Plan:
- Basic frame:
  - Stimulus: write addr0=24'hFF00D5, addr1=24'h123456; START with PIXEL_COUNT=2; PIX_READY=1.
  - Required: PIX_DATA=24'hD5FF00 then 24'h561234; PIX_VALID first at t+2; FRAME_DONE single pulse one cycle after the second handshake.
- Backpressure:
  - Stimulus: hold PIX_READY=0 for 50 cycles on pixel 0.
  - Required: PIX_VALID=1 and PIX_DATA constant throughout; exactly one handshake on release.
- Counts and addresses:
  - PIXEL_COUNT=0: no BUSY, no FRAME_DONE.
  - PIXEL_COUNT=15 with PIXELS=8: exactly 8 words, index wraps to IDLE.
  - WR_ADDR=9: no buffer change.
- Busy and read-first:
  - Stimulus: START pulsed while BUSY.
  - Required: ignored, frame length unchanged.
  - Stimulus: write to the pixel being fetched in the same cycle.
  - Required: old value presented, new value on the next frame.
- Reset:
  - Stimulus: RESET_N low during PRESENT of pixel 1 of 4.
  - Required: PIX_VALID=0 and BUSY=0 asynchronously; no FRAME_DONE; a new START sends from pixel 0.
- With NEOPIXEL_FETCH_BRIGHTNESS_EN:
  - BRIGHTNESS=127, pixel 24'hFF8002 gives PIX_DATA 24'h017F40.
  - BRIGHTNESS=255 gives an unchanged word.
  - START-to-VALID is 3 cycles.

Source files
------------

// File: rtl/neopixel_pkg.sv
// Shared widths, byte-lane positions and fetch state encoding for the NeoPixel frame fetcher.
package neopixel_pkg;

    localparam int PIX_W = 24;

    // Host order is {R, G, B}; the serializer wants G first on the wire, i.e. {B, R, G}.
    localparam int HOST_R_LSB = 16;
    localparam int HOST_G_LSB = 8;
    localparam int HOST_B_LSB = 0;
    localparam int WIRE_G_LSB = 0;
    localparam int WIRE_R_LSB = 8;
    localparam int WIRE_B_LSB = 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SCALE,
        PRESENT,
        DONE
    } fetchState_t;

    function automatic logic [PIX_W-1:0] hostToWire(input logic [PIX_W-1:0] host);
        logic [PIX_W-1:0] wireWord;
        wireWord = '0;
        wireWord[WIRE_G_LSB +: 8] = host[HOST_G_LSB +: 8];
        wireWord[WIRE_R_LSB +: 8] = host[HOST_R_LSB +: 8];
        wireWord[WIRE_B_LSB +: 8] = host[HOST_B_LSB +: 8];
        return wireWord;
    endfunction

endpackage

// File: rtl/neopixel_pixel_ram.sv
// Frame buffer: one write port, one synchronous read-first read port, no reset on contents.
module neopixel_pixel_ram
    import neopixel_pkg::*;
#(
    parameter int PIXELS = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk_i,
    input  logic              wrEn_i,
    input  logic [ADDR_W-1:0] wrAddr_i,
    input  logic [PIX_W-1:0]  wrData_i,
    input  logic              rdEn_i,
    input  logic [ADDR_W-1:0] rdAddr_i,
    output logic [PIX_W-1:0]  rdData_o
);

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(PIXELS);

    logic [PIX_W-1:0] mem [PIXELS];

    // Both ports update on the same edge, so a colliding read sees the pre-write word.
    always_ff @(posedge clk_i) begin
        if (wrEn_i && ({1'b0, wrAddr_i} < DEPTH)) begin
            mem[wrAddr_i] <= wrData_i;
        end
        if (rdEn_i) begin
            rdData_o <= mem[rdAddr_i];
        end
    end

endmodule

// File: rtl/neopixel_frame_fetch.sv
// Streams the pixel frame to the NeoPixel serializer in wire order over valid/ready.
// Optional per-channel brightness scaling: define NEOPIXEL_FETCH_BRIGHTNESS_EN.
module neopixel_frame_fetch
    import neopixel_pkg::*;
#(
    parameter int PIXELS = 8,
    parameter int ADDR_W = 3
) (
    input  logic              CLK_10MHZ,
    input  logic              RESET_N,
    input  logic              WR_EN,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [23:0]       WR_DATA,
    input  logic              START,
    input  logic [ADDR_W:0]   PIXEL_COUNT,
    input  logic [7:0]        BRIGHTNESS,
    output logic [23:0]       PIX_DATA,
    output logic              PIX_VALID,
    input  logic              PIX_READY,
    output logic              BUSY,
    output logic              FRAME_DONE
);

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(PIXELS);

    fetchState_t       state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              rdEn;
    logic [PIX_W-1:0]  rdData;
    logic [PIX_W-1:0]  presentWord;
    logic              lastPixel;

    neopixel_pixel_ram #(
        .PIXELS (PIXELS),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i    (CLK_10MHZ),
        .wrEn_i   (WR_EN),
        .wrAddr_i (WR_ADDR),
        .wrData_i (WR_DATA),
        .rdEn_i   (rdEn),
        .rdAddr_i (index_q),
        .rdData_o (rdData)
    );

    assign lastPixel = ({1'b0, index_q} == (count_q - (ADDR_W + 1)'(1)));

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        count_d = count_q;
        rdEn    = 1'b0;
        case (state_q)
            IDLE: begin
                if (START && (PIXEL_COUNT != '0)) begin
                    count_d = (PIXEL_COUNT > DEPTH) ? DEPTH : PIXEL_COUNT;
                    index_d = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                rdEn = 1'b1;
`ifdef NEOPIXEL_FETCH_BRIGHTNESS_EN
                state_d = SCALE;
`else
                state_d = PRESENT;
`endif
            end
            SCALE:   state_d = PRESENT;
            PRESENT: begin
                if (PIX_READY) begin
                    if (lastPixel) begin
                        state_d = DONE;
                    end else begin
                        index_d = index_q + ADDR_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_10MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            index_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            count_q <= count_d;
        end
    end

`ifdef NEOPIXEL_FETCH_BRIGHTNESS_EN
    logic [PIX_W-1:0] pixData_q, pixData_d;

    function automatic logic [7:0] scaleChan(input logic [7:0] chan, input logic [7:0] level);
        logic [15:0] prod;
        prod = 16'(chan) * (16'(level) + 16'd1);
        return prod[15:8];
    endfunction

    // The scaled word is registered so the multipliers sit off the serializer-facing path.
    always_comb begin
        pixData_d = pixData_q;
        if (state_q == SCALE) begin
            pixData_d = hostToWire({scaleChan(rdData[HOST_R_LSB +: 8], BRIGHTNESS),
                                    scaleChan(rdData[HOST_G_LSB +: 8], BRIGHTNESS),
                                    scaleChan(rdData[HOST_B_LSB +: 8], BRIGHTNESS)});
        end
    end

    always_ff @(posedge CLK_10MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            pixData_q <= '0;
        end else begin
            pixData_q <= pixData_d;
        end
    end

    assign presentWord = pixData_q;
`else
    logic unusedBrightness;
    assign unusedBrightness = ^BRIGHTNESS;
    assign presentWord      = hostToWire(rdData);
`endif

    assign PIX_VALID  = (state_q == PRESENT);
    assign BUSY       = (state_q != IDLE);
    assign FRAME_DONE = (state_q == DONE);
    assign PIX_DATA   = PIX_VALID ? presentWord : '0;

endmodule

// File: tb/tb_neopixel_frame_fetch.sv
// Scoreboard bench for neopixel_frame_fetch; follows NEOPIXEL_FETCH_BRIGHTNESS_EN when defined.
`timescale 1ns/1ps
module tb_neopixel_frame_fetch;

    localparam int PIXELS = 8;
    localparam int ADDR_W = 3;

    logic        clk = 1'b0;
    logic        rstN;
    logic        wrEn, wrEn9, start, start9, pixReady;
    logic [2:0]  wrAddr;
    logic [3:0]  wrAddr9, pixCount;
    logic [4:0]  pixCount9;
    logic [23:0] wrData;
    logic [7:0]  brightness;
    logic [23:0] pixData, pixData9;
    logic        pixValid, busy, frameDone, pixValid9, busy9, frameDone9;

    int checks = 0;
    int fails  = 0;
    int hsCount = 0, doneCount = 0, hsCount9 = 0;
    logic prevHs = 1'b0;
    logic [23:0] expQ[$];
    logic [23:0] expQ9[$];
    logic [23:0] model  [PIXELS];
    logic [23:0] model9 [9];

`ifdef NEOPIXEL_FETCH_BRIGHTNESS_EN
    localparam int PAT_LEN = 8;
    logic [2:0] basicPat [PAT_LEN] = '{3'b001, 3'b001, 3'b101, 3'b001, 3'b001, 3'b101, 3'b011, 3'b000};
`else
    localparam int PAT_LEN = 6;
    logic [2:0] basicPat [PAT_LEN] = '{3'b001, 3'b101, 3'b001, 3'b101, 3'b011, 3'b000};
`endif

    always #50 clk = ~clk;

    neopixel_frame_fetch #(.PIXELS(PIXELS), .ADDR_W(ADDR_W)) u_dut (
        .CLK_10MHZ(clk), .RESET_N(rstN), .WR_EN(wrEn), .WR_ADDR(wrAddr), .WR_DATA(wrData),
        .START(start), .PIXEL_COUNT(pixCount), .BRIGHTNESS(brightness), .PIX_DATA(pixData),
        .PIX_VALID(pixValid), .PIX_READY(pixReady), .BUSY(busy), .FRAME_DONE(frameDone)
    );

    // Non-power-of-two instance so an out-of-range write address is expressible.
    neopixel_frame_fetch #(.PIXELS(9), .ADDR_W(4)) u_dut9 (
        .CLK_10MHZ(clk), .RESET_N(rstN), .WR_EN(wrEn9), .WR_ADDR(wrAddr9), .WR_DATA(wrData),
        .START(start9), .PIXEL_COUNT(pixCount9), .BRIGHTNESS(brightness), .PIX_DATA(pixData9),
        .PIX_VALID(pixValid9), .PIX_READY(1'b1), .BUSY(busy9), .FRAME_DONE(frameDone9)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [23:0] toWire(input logic [23:0] h);
        return {h[7:0], h[23:16], h[15:8]};
    endfunction

    function automatic logic [7:0] scaleModel(input logic [7:0] c, input logic [7:0] b);
        int p;
        p = (int'(c) * (int'(b) + 1)) / 256;
        return 8'(p);
    endfunction

    function automatic logic [23:0] expWord(input logic [23:0] h);
`ifdef NEOPIXEL_FETCH_BRIGHTNESS_EN
        return toWire({scaleModel(h[23:16], brightness), scaleModel(h[15:8], brightness),
                       scaleModel(h[7:0], brightness)});
`else
        return toWire(h);
`endif
    endfunction

    always @(negedge clk) begin
        if (frameDone) begin
            doneCount++;
            checkOutput("doneAfterLastHs", {30'd0, prevHs, (expQ.size() == 0)}, 32'd3);
        end
        prevHs = 1'b0;
        if (pixValid && pixReady) begin
            hsCount++;
            prevHs = 1'b1;
            if (expQ.size() == 0) checkOutput("extraWord", {8'd0, pixData}, 32'hFFFF_FFFF);
            else checkOutput("pixData", {8'd0, pixData}, {8'd0, expQ.pop_front()});
        end
        if (pixValid9) begin
            hsCount9++;
            if (expQ9.size() == 0) checkOutput("extraWord9", {8'd0, pixData9}, 32'hFFFF_FFFF);
            else checkOutput("pixData9", {8'd0, pixData9}, {8'd0, expQ9.pop_front()});
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic writePix(input int addr, input logic [23:0] data);
        wrEn = 1'b1; wrAddr = 3'(addr); wrData = data;
        model[addr] = data;
        step();
        wrEn = 1'b0;
    endtask

    task automatic writePix9(input int addr, input logic [23:0] data);
        wrEn9 = 1'b1; wrAddr9 = 4'(addr); wrData = data;
        if (addr < 9) model9[addr] = data;
        step();
        wrEn9 = 1'b0;
    endtask

    task automatic pushFrame(input int n);
        int eff;
        eff = (n > PIXELS) ? PIXELS : n;
        for (int i = 0; i < eff; i++) expQ.push_back(expWord(model[i]));
    endtask

    task automatic applyStimulus(input int count);
        start = 1'b1; pixCount = 4'(count);
        step();
        start = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while (busy && n < 400) begin step(); n++; end
        checkOutput(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic waitValid(input string tag);
        int n;
        n = 0;
        while (!pixValid && n < 20) begin step(); n++; end
        checkOutput(tag, {31'd0, pixValid}, 32'd1);
    endtask

    initial begin
        int hs0, d0, bad;
        logic [23:0] held;
        rstN = 1'b0; wrEn = 1'b0; wrEn9 = 1'b0; wrAddr = '0; wrAddr9 = '0; wrData = '0;
        start = 1'b0; start9 = 1'b0; pixCount = '0; pixCount9 = '0;
        brightness = 8'd255; pixReady = 1'b1;
        repeat (2) step();
        checkOutput("rstValid", {31'd0, pixValid}, 32'd0);
        checkOutput("rstBusy",  {31'd0, busy},     32'd0);
        checkOutput("rstDone",  {31'd0, frameDone}, 32'd0);
        checkOutput("rstData",  {8'd0, pixData},   32'd0);
        rstN = 1'b1;
        step();

        writePix(0, 24'hFF00D5);
        writePix(1, 24'h123456);
        for (int i = 2; i < PIXELS; i++) writePix(i, 24'($urandom));

        hs0 = hsCount; d0 = doneCount;
        pushFrame(2);
        applyStimulus(2);
        for (int k = 0; k < PAT_LEN; k++) begin
            checkOutput($sformatf("basicSeq%0d", k), {29'd0, pixValid, frameDone, busy}, {29'd0, basicPat[k]});
            step();
        end
        checkOutput("basicWords", hsCount - hs0, 2);
        checkOutput("basicDone", doneCount - d0, 1);

        pixReady = 1'b0; hs0 = hsCount;
        pushFrame(1);
        applyStimulus(1);
        waitValid("bpValid");
        held = pixData;
        checkOutput("bpWord", {8'd0, held}, 32'h00D5FF00);
        bad = 0;
        repeat (50) begin
            step();
            if (!pixValid || pixData !== held) bad++;
        end
        checkOutput("bpStable", bad, 0);
        checkOutput("bpNoHs", hsCount - hs0, 0);
        pixReady = 1'b1;
        waitIdle("bpIdle");
        checkOutput("bpOneHs", hsCount - hs0, 1);

        d0 = doneCount; bad = 0;
        applyStimulus(0);
        repeat (4) begin
            if (busy) bad++;
            step();
        end
        checkOutput("cnt0Busy", bad, 0);
        checkOutput("cnt0Done", doneCount - d0, 0);

        hs0 = hsCount; d0 = doneCount;
        pushFrame(15);
        applyStimulus(15);
        waitIdle("cnt15Idle");
        checkOutput("cnt15Words", hsCount - hs0, 8);
        checkOutput("cnt15Done", doneCount - d0, 1);

        hs0 = hsCount; d0 = doneCount;
        pushFrame(3);
        start = 1'b1; pixCount = 4'd3;
        step();
        pixCount = 4'd5;
        bad = 0;
        while (busy && bad < 100) begin step(); bad++; end
        start = 1'b0;
        step();
        checkOutput("busyStartIdle", {31'd0, busy}, 32'd0);
        checkOutput("busyStartWords", hsCount - hs0, 3);
        checkOutput("busyStartDone", doneCount - d0, 1);

        hs0 = hsCount;
        pushFrame(1);
        applyStimulus(1);
        wrEn = 1'b1; wrAddr = 3'd0; wrData = 24'hA1B2C3;
        model[0] = 24'hA1B2C3;
        step();
        wrEn = 1'b0;
        waitIdle("rfIdle1");
        pushFrame(1);
        applyStimulus(1);
        waitIdle("rfIdle2");
        checkOutput("rfWords", hsCount - hs0, 2);

        pixReady = 1'b0; d0 = doneCount;
        pushFrame(4);
        applyStimulus(4);
        waitValid("rstP0Valid");
        pixReady = 1'b1;
        step();
        pixReady = 1'b0;
        waitValid("rstP1Valid");
        #20 rstN = 1'b0;
        #1;
        checkOutput("asyncValid", {31'd0, pixValid}, 32'd0);
        checkOutput("asyncBusy",  {31'd0, busy},     32'd0);
        expQ.delete();
        step();
        rstN = 1'b1;
        step();
        checkOutput("rstNoDone", doneCount - d0, 0);
        pixReady = 1'b1;
        pushFrame(2);
        applyStimulus(2);
        waitIdle("rstRestartIdle");
        checkOutput("rstRestartDone", doneCount - d0, 1);

`ifdef NEOPIXEL_FETCH_BRIGHTNESS_EN
        pixReady = 1'b0; brightness = 8'd127;
        writePix(0, 24'hFF8002);
        pushFrame(1);
        applyStimulus(1);
        waitValid("b127Valid");
        checkOutput("bright127", {8'd0, pixData}, 32'h00017F40);
        pixReady = 1'b1;
        waitIdle("b127Idle");
        pixReady = 1'b0; brightness = 8'd255;
        pushFrame(1);
        applyStimulus(1);
        waitValid("b255Valid");
        checkOutput("bright255", {8'd0, pixData}, 32'h0002FF80);
        pixReady = 1'b1;
        waitIdle("b255Idle");
`endif

        for (int i = 0; i < 9; i++) writePix9(i, {8'(i), 8'hA5, 8'(255 - i)});
        writePix9(9, 24'hDEAD00);
        for (int i = 0; i < 9; i++) expQ9.push_back(expWord(model9[i]));
        hs0 = hsCount9;
        start9 = 1'b1; pixCount9 = 5'd15;
        step();
        start9 = 1'b0;
        bad = 0;
        while (busy9 && bad < 200) begin step(); bad++; end
        checkOutput("d9Idle", {31'd0, busy9}, 32'd0);
        checkOutput("d9Words", hsCount9 - hs0, 9);
        checkOutput("d9QueueEmpty", expQ9.size(), 0);
        checkOutput("queueEmpty", expQ.size(), 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
